ex_muldiv_unit: RTL and testbench

//  Execute-stage iterative multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI/MTLO).

---
 rtl/ex_muldiv_unit_pkg.sv | 29 ++
 rtl/ex_muldiv_unit_sign_fix.sv | 17 +
 rtl/ex_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//  - md_op_e    : opcode encodings carried on i_op (MD_MULT..MD_DIVU)
//  - md_state_e : sequencer states (ST_IDLE, ST_RUN, ST_FIX, ST_DONE)
//  - is_signed_op / is_div_op : opcode classification helpers
package muldiv_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Combinational magnitude / conditional negate helper.
// Used both to take |operand| on launch and to re-apply the result sign.
// Ports:
//  val  in   W  value to process
//  neg  in   1  when high, output is the two's complement negation of val
//  res  out  W  val or -val
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with architectural HI/LO.
// Handles MULT, MULTU, DIV, DIVU (radix-2, one step per cycle) plus MTHI/MTLO.
// Optional build macro: MULDIV_EARLY_OUT_EN lets multiplies finish as soon as
// the remaining multiplier bits are zero; divides always take NBITS steps.
// Ports:
//  i_clk    in   1      clock
//  i_rst_n  in   1      synchronous active-low reset
//  i_start  in   1      launch request (operands/opcode valid this cycle)
//  i_op     in   2      MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//  i_src_a  in   NBITS  multiplicand / dividend, also MTHI/MTLO data
//  i_src_b  in   NBITS  multiplier / divisor
//  i_hi_wr  in   1      MTHI write strobe
//  i_lo_wr  in   1      MTLO write strobe
//  i_flush  in   1      abort a running operation
//  o_stall  out  1      pipeline freeze request
//  o_busy   out  1      high in any non-IDLE state
//  o_done   out  1      one-cycle pulse, HI/LO valid
//  o_hi     out  NBITS  HI register
//  o_lo     out  NBITS  LO register
module ex_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [NBITS-1:0] i_src_a,
  input  logic [NBITS-1:0] i_src_b,
  input  logic             i_hi_wr,
  input  logic             i_lo_wr,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo
);

  localparam int CW = $clog2(NBITS + 1);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q;
  logic [NBITS-1:0]   a_raw_q;
  logic [NBITS-1:0]   b_mag_q;
  logic [NBITS-1:0]   mplier_q;
  logic [NBITS-1:0]   quo_q;
  logic [NBITS-1:0]   rem_q;
  logic [NBITS-1:0]   hi_q, lo_q;
  logic [2*NBITS-1:0] prod_q;
  logic [2*NBITS-1:0] mcand_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div0_q;
  logic [CW-1:0]      count_q;

  logic [NBITS-1:0]   a_abs, b_abs;
  logic [NBITS-1:0]   quo_fix, rem_fix;
  logic [2*NBITS-1:0] prod_fix;
  logic [2*NBITS-1:0] prod_step;
  logic [NBITS:0]     div_shift;
  logic [NBITS-1:0]   div_diff;
  logic               div_ge;
  logic               last_step;
  logic               mul_early;
  logic               launch;
  logic               start_signed;

  // Flush beats start in IDLE, so a squashed instruction never launches.
  assign launch       = (state_q == ST_IDLE) && i_start && !i_flush;
  assign start_signed = is_signed_op(i_op);

  muldiv_sign_fix #(.W(NBITS)) u_abs_a (
    .val (i_src_a),
    .neg (start_signed & i_src_a[NBITS-1]),
    .res (a_abs)
  );

  muldiv_sign_fix #(.W(NBITS)) u_abs_b (
    .val (i_src_b),
    .neg (start_signed & i_src_b[NBITS-1]),
    .res (b_abs)
  );

  muldiv_sign_fix #(.W(2*NBITS)) u_fix_prod (
    .val (prod_q),
    .neg (neg_q),
    .res (prod_fix)
  );

  muldiv_sign_fix #(.W(NBITS)) u_fix_quo (
    .val (quo_q),
    .neg (neg_q),
    .res (quo_fix)
  );

  muldiv_sign_fix #(.W(NBITS)) u_fix_rem (
    .val (rem_q),
    .neg (rem_neg_q),
    .res (rem_fix)
  );

  // Shift-add multiply step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  // Restoring divide step. The shifted partial remainder needs NBITS+1 bits;
  // once it is known to be >= divisor the difference fits back in NBITS.
  assign div_shift = {rem_q, quo_q[NBITS-1]};
  assign div_ge    = (div_shift >= {1'b0, b_mag_q});
  assign div_diff  = div_shift[NBITS-1:0] - b_mag_q;

  assign last_step = (count_q == CW'(NBITS - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // After this step only mplier_q[NBITS-1:1] remains; if it is zero no further
  // partial products can change the result.
  assign mul_early = !is_div_op(op_q) && (mplier_q[NBITS-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the pipeline stall request.
  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_stall = i_start;
        if (launch) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_stall = 1'b1;
        if (i_flush) begin
          state_d = ST_IDLE;
        end else if (last_step || mul_early) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        o_stall = 1'b1;
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration registers and HI/LO.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q      <= '0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      mplier_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            op_q      <= i_op;
            a_raw_q   <= i_src_a;
            b_mag_q   <= b_abs;
            mplier_q  <= b_abs;
            mcand_q   <= {{NBITS{1'b0}}, a_abs};
            prod_q    <= '0;
            quo_q     <= a_abs;
            rem_q     <= '0;
            neg_q     <= start_signed & (i_src_a[NBITS-1] ^ i_src_b[NBITS-1]);
            rem_neg_q <= start_signed & i_src_a[NBITS-1];
            div0_q    <= is_div_op(i_op) && (i_src_b == '0);
            count_q   <= '0;
          end else if (!i_start) begin
            // MTHI/MTLO only when no launch is being requested.
            if (i_hi_wr) begin
              hi_q <= i_src_a;
            end
            if (i_lo_wr) begin
              lo_q <= i_src_a;
            end
          end
        end
        ST_RUN: begin
          if (!i_flush) begin
            count_q <= count_q + CW'(1);
            if (is_div_op(op_q)) begin
              rem_q <= div_ge ? div_diff : div_shift[NBITS-1:0];
              quo_q <= {quo_q[NBITS-2:0], div_ge};
            end else begin
              prod_q   <= prod_step;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
          end
        end
        ST_FIX: begin
          if (!i_flush) begin
            if (div0_q) begin
              hi_q <= a_raw_q;
              lo_q <= '1;
            end else if (is_div_op(op_q)) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit at NBITS=32.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
module tb_ex_muldiv_unit;
  import muldiv_defs::*;

  localparam int NBITS    = 32;
  localparam int LAT_FULL = NBITS + 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_MUL_B3 = 4;
  localparam int LAT_MUL_B7 = 5;
`else
  localparam int LAT_MUL_B3 = NBITS + 2;
  localparam int LAT_MUL_B7 = NBITS + 2;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [1:0]       i_op = '0;
  logic [NBITS-1:0] i_src_a = '0;
  logic [NBITS-1:0] i_src_b = '0;
  logic             i_hi_wr = 1'b0;
  logic             i_lo_wr = 1'b0;
  logic             i_flush = 1'b0;
  logic             o_stall;
  logic             o_busy;
  logic             o_done;
  logic [NBITS-1:0] o_hi;
  logic [NBITS-1:0] o_lo;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cycles;
  int   stall_cycles;
  bit   done_seen;
  logic stall_at_start;

  ex_muldiv_unit #(.NBITS(NBITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_src_a (i_src_a),
    .i_src_b (i_src_b),
    .i_hi_wr (i_hi_wr),
    .i_lo_wr (i_lo_wr),
    .i_flush (i_flush),
    .o_stall (o_stall),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  always #5 i_clk = ~i_clk;

  // Launch one operation: start held for exactly one rising edge.
  task automatic launch(input logic [1:0] op, input logic [NBITS-1:0] a,
                        input logic [NBITS-1:0] b);
    @(negedge i_clk);
    i_op    = op;
    i_src_a = a;
    i_src_b = b;
    i_start = 1'b1;
    #1 stall_at_start = o_stall;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  // Count cycles after the start cycle until o_done, bounded.
  task automatic run_to_done();
    cycles       = 0;
    stall_cycles = 0;
    done_seen    = 0;
    while (!done_seen && cycles < 100) begin
      @(negedge i_clk);
      cycles++;
      if (o_stall) stall_cycles++;
      if (o_done) done_seen = 1;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", o_done); end
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall got %b want 0", o_stall); end
    n_checks++; if (o_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 0", o_hi); end
    n_checks++; if (o_lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo got %h want 0", o_lo); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_multu();
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done();
    n_checks++; if (stall_at_start !== 1'b1) begin n_fail++; $display("[TB] FAIL multu_stall_start got %b want 1", stall_at_start); end
    n_checks++; if (!done_seen || cycles != LAT_FULL) begin n_fail++; $display("[TB] FAIL multu_latency got %0d (seen=%0d) want %0d", cycles, done_seen, LAT_FULL); end
    n_checks++; if (stall_cycles != LAT_FULL - 1) begin n_fail++; $display("[TB] FAIL multu_stall_cycles got %0d want %0d", stall_cycles, LAT_FULL - 1); end
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL multu_stall_in_done got %b want 0", o_stall); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL multu_busy_in_done got %b want 1", o_busy); end
    n_checks++; if (o_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("[TB] FAIL multu_hi got %h want fffffffe", o_hi); end
    n_checks++; if (o_lo !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL multu_lo got %h want 00000001", o_lo); end
    @(negedge i_clk);
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("[TB] FAIL multu_done_pulse got %b want 0", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL multu_busy_after got %b want 0", o_busy); end
  endtask

  task automatic test_mult();
    launch(MD_MULT, 32'hFFFF_FFF9, 32'd3);
    run_to_done();
    n_checks++; if (!done_seen || cycles != LAT_MUL_B3) begin n_fail++; $display("[TB] FAIL mult_latency got %0d (seen=%0d) want %0d", cycles, done_seen, LAT_MUL_B3); end
    n_checks++; if (o_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mult_hi got %h want ffffffff", o_hi); end
    n_checks++; if (o_lo !== 32'hFFFF_FFEB) begin n_fail++; $display("[TB] FAIL mult_lo got %h want ffffffeb", o_lo); end
    @(negedge i_clk);
  endtask

  task automatic test_divide();
    logic [1:0]       ops[4];
    logic [NBITS-1:0] av[4], bv[4], hv[4], lv[4];
    ops[0] = MD_DIVU; av[0] = 32'd100;       bv[0] = 32'd7;         lv[0] = 32'd14;        hv[0] = 32'd2;
    ops[1] = MD_DIV;  av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2;         lv[1] = 32'hFFFF_FFFD; hv[1] = 32'hFFFF_FFFF;
    ops[2] = MD_DIV;  av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF; lv[2] = 32'h8000_0000; hv[2] = 32'h0;
    ops[3] = MD_DIVU; av[3] = 32'd5;         bv[3] = 32'd0;         lv[3] = 32'hFFFF_FFFF; hv[3] = 32'd5;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], av[i], bv[i]);
      run_to_done();
      n_checks++; if (!done_seen || cycles != LAT_FULL) begin n_fail++; $display("[TB] FAIL div%0d_latency got %0d (seen=%0d) want %0d", i, cycles, done_seen, LAT_FULL); end
      n_checks++; if (o_lo !== lv[i]) begin n_fail++; $display("[TB] FAIL div%0d_lo got %h want %h", i, o_lo, lv[i]); end
      n_checks++; if (o_hi !== hv[i]) begin n_fail++; $display("[TB] FAIL div%0d_hi got %h want %h", i, o_hi, hv[i]); end
      @(negedge i_clk);
    end
  endtask

  // Follows the divide-by-zero case, so LO holds all ones on entry.
  task automatic test_mthi_mtlo();
    @(negedge i_clk);
    i_hi_wr = 1'b1;
    i_src_a = 32'h0000_1234;
    @(negedge i_clk);
    i_hi_wr = 1'b0;
    n_checks++; if (o_hi !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL mthi_hi got %h want 00001234", o_hi); end
    n_checks++; if (o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mthi_lo_kept got %h want ffffffff", o_lo); end
    i_lo_wr = 1'b1;
    i_start = 1'b1;
    i_op    = MD_DIVU;
    i_src_a = 32'h55;
    i_src_b = 32'd5;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    i_lo_wr = 1'b0;
    @(negedge i_clk);
    n_checks++; if (o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mtlo_dropped got %h want ffffffff", o_lo); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mtlo_start_busy got %b want 1", o_busy); end
    run_to_done();
    n_checks++; if (!done_seen) begin n_fail++; $display("[TB] FAIL mtlo_start_done got timeout want done"); end
    n_checks++; if (o_lo !== 32'h11) begin n_fail++; $display("[TB] FAIL mtlo_start_lo got %h want 00000011", o_lo); end
    n_checks++; if (o_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL mtlo_start_hi got %h want 0", o_hi); end
    @(negedge i_clk);
  endtask

  task automatic test_flush_reset();
    bit got_done;
    @(negedge i_clk);
    i_hi_wr = 1'b1;
    i_lo_wr = 1'b1;
    i_src_a = 32'hAA;
    @(negedge i_clk);
    i_hi_wr = 1'b0;
    i_lo_wr = 1'b0;
    launch(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy got %b want 0", o_busy); end
    n_checks++; if (o_hi !== 32'hAA) begin n_fail++; $display("[TB] FAIL flush_hi got %h want 000000aa", o_hi); end
    n_checks++; if (o_lo !== 32'hAA) begin n_fail++; $display("[TB] FAIL flush_lo got %h want 000000aa", o_lo); end
    got_done = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) got_done = 1;
    end
    n_checks++; if (got_done) begin n_fail++; $display("[TB] FAIL flush_no_done got done=1 want 0"); end

    launch(MD_DIVU, 32'd1000, 32'd3);
    repeat (4) @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_run_busy got %b want 0", o_busy); end
    n_checks++; if (o_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_run_hi got %h want 0", o_hi); end
    n_checks++; if (o_lo !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_run_lo got %h want 0", o_lo); end
    got_done = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) got_done = 1;
    end
    n_checks++; if (got_done) begin n_fail++; $display("[TB] FAIL rst_run_no_done got done=1 want 0"); end
  endtask

  task automatic test_start_ignored();
    launch(MD_MULTU, 32'd6, 32'd7);
    cycles    = 0;
    done_seen = 0;
    while (!done_seen && cycles < 100) begin
      @(negedge i_clk);
      cycles++;
      if (cycles == 2) begin
        i_start = 1'b1;
        i_op    = MD_DIVU;
        i_src_a = 32'd100;
        i_src_b = 32'd7;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) done_seen = 1;
    end
    n_checks++; if (!done_seen || cycles != LAT_MUL_B7) begin n_fail++; $display("[TB] FAIL ign_run_latency got %0d (seen=%0d) want %0d", cycles, done_seen, LAT_MUL_B7); end
    n_checks++; if (o_lo !== 32'd42) begin n_fail++; $display("[TB] FAIL ign_run_lo got %h want 0000002a", o_lo); end
    n_checks++; if (o_hi !== 32'd0) begin n_fail++; $display("[TB] FAIL ign_run_hi got %h want 0", o_hi); end
    i_start = 1'b1;
    i_op    = MD_MULTU;
    i_src_a = 32'd3;
    i_src_b = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_done_busy got %b want 0", o_busy); end
    @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0 || o_lo !== 32'd42) begin n_fail++; $display("[TB] FAIL ign_done_idle got busy=%b lo=%h want busy=0 lo=0000002a", o_busy, o_lo); end
    launch(MD_MULTU, 32'd3, 32'd3);
    run_to_done();
    n_checks++; if (!done_seen || cycles != LAT_MUL_B3) begin n_fail++; $display("[TB] FAIL idle_start_latency got %0d (seen=%0d) want %0d", cycles, done_seen, LAT_MUL_B3); end
    n_checks++; if (o_lo !== 32'd9 || o_hi !== 32'd0) begin n_fail++; $display("[TB] FAIL idle_start_result got hi=%h lo=%h want hi=0 lo=00000009", o_hi, o_lo); end
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_divide();
    test_mthi_mtlo();
    test_flush_reset();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
